// File: rtl/sd_spi_pkg.sv
// Shared types and constants for the SD-card SPI master PHY.
package sd_spi_pkg;

    localparam int unsigned CMD_W_DEF      = 48;
    localparam int unsigned RSP_W_DEF      = 80;
    localparam int unsigned PWRUP_CLKS_DEF = 80;
    localparam int unsigned CNT_W          = 8;

    localparam logic [1:0] DivH1 = 2'b00;
    localparam logic [1:0] DivH2 = 2'b01;
    localparam logic [1:0] DivH4 = 2'b10;
    localparam logic [1:0] DivH8 = 2'b11;

    typedef enum logic [2:0] {
        StIdle,
        StPwrup,
        StTx,
        StRx,
        StDone
    } spi_state_e;

    // Terminal count of the half-period counter: H-1 where H = 2^div.
    function automatic logic [2:0] half_period_last(input logic [1:0] div);
        case (div)
            DivH1:   return 3'd0;
            DivH2:   return 3'd1;
            DivH4:   return 3'd3;
            DivH8:   return 3'd7;
            default: return 3'd7;
        endcase
    endfunction

endpackage

// File: rtl/sd_spi_if.sv
// Controller-side request/response bundle of the SD SPI master PHY.
interface sd_spi_if
    import sd_spi_pkg::*;
#(
    parameter int unsigned CMD_W = CMD_W_DEF,
    parameter int unsigned RSP_W = RSP_W_DEF
) ();

    logic             spi_soft_rst_i;
    logic             spi_start_i;
    logic             spi_fbo_i;
    logic [1:0]       clock_divider_i;
    logic [CMD_W-1:0] instruction_sd_i;
    logic [RSP_W-1:0] spi_data_o;
    logic             spi_done_o;
    logic             spi_busy_o;

    modport master (
        input  spi_soft_rst_i,
        input  spi_start_i,
        input  spi_fbo_i,
        input  clock_divider_i,
        input  instruction_sd_i,
        output spi_data_o,
        output spi_done_o,
        output spi_busy_o
    );

    modport slave (
        output spi_soft_rst_i,
        output spi_start_i,
        output spi_fbo_i,
        output clock_divider_i,
        output instruction_sd_i,
        input  spi_data_o,
        input  spi_done_o,
        input  spi_busy_o
    );

endinterface

// File: rtl/sd_spi_clkgen.sv
// SCK generator: half-period counter with one-cycle rise/fall strobes that
// coincide with the clk edge on which SCK changes.
module sd_spi_clkgen
    import sd_spi_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       en_i,
    input  logic       abort_i,
    input  logic [1:0] div_i,
    output logic       sck_o,
    output logic       rise_o,
    output logic       fall_o
);

    logic [2:0] cnt_q, cnt_d;
    logic       sck_q, sck_d;
    logic       last;
    logic       run;

    assign run  = en_i && !abort_i;
    assign last = (cnt_q == half_period_last(div_i));

    always_comb begin
        cnt_d = cnt_q;
        sck_d = sck_q;
        if (!run) begin
            cnt_d = 3'd0;
            sck_d = 1'b0;
        end else if (last) begin
            cnt_d = 3'd0;
            sck_d = !sck_q;
        end else begin
            cnt_d = cnt_q + 3'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= 3'd0;
            sck_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            sck_q <= sck_d;
        end
    end

    assign sck_o  = sck_q;
    assign rise_o = run && last && !sck_q;
    assign fall_o = run && last && sck_q;

endmodule

// File: rtl/sd_spi_master.sv
// SD-card SPI master PHY: shifts out a command frame, captures a response window.
// Optional power-up dummy clocks are enabled with `define SD_SPI_POWERUP_CLKS_EN.
module sd_spi_master
    import sd_spi_pkg::*;
#(
    parameter int unsigned CMD_W = CMD_W_DEF,
    parameter int unsigned RSP_W = RSP_W_DEF
) (
    input  logic     spi_clk_i,
    input  logic     spi_rst_i,
    sd_spi_if.master ctrl_io,
    output logic     sd_sck_o,
    output logic     sd_cs_n_o,
    output logic     sd_mosi_o,
    input  logic     sd_miso_i
);

    spi_state_e       state_q, state_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [CMD_W-1:0] tx_sr_q, tx_sr_d;
    logic [RSP_W-1:0] rx_sr_q, rx_sr_d;
    logic [RSP_W-1:0] data_q, data_d;
    logic [1:0]       div_q, div_d;
    logic             mosi_q, mosi_d;
    logic             armed_q, armed_d;
    logic [CMD_W-1:0] cmd_rev;
    logic             accept, busy, need_pwrup;
    logic             sck_rise, sck_fall;

    always_comb begin
        for (int i = 0; i < CMD_W; i++) begin
            cmd_rev[i] = ctrl_io.instruction_sd_i[CMD_W-1-i];
        end
    end

    assign busy   = state_q inside {StPwrup, StTx, StRx};
    assign accept = (state_q == StIdle) && ctrl_io.spi_start_i && armed_q;

`ifdef SD_SPI_POWERUP_CLKS_EN
    logic pwrup_done_q;

    // Survives soft reset so the dummy clocks run once per hard reset.
    always_ff @(posedge spi_clk_i or negedge spi_rst_i) begin
        if (!spi_rst_i) begin
            pwrup_done_q <= 1'b0;
        end else if (state_q == StPwrup && state_d == StTx) begin
            pwrup_done_q <= 1'b1;
        end
    end

    assign need_pwrup = !pwrup_done_q;
`else
    assign need_pwrup = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        tx_sr_d   = tx_sr_q;
        rx_sr_d   = rx_sr_q;
        data_d    = data_q;
        div_d     = div_q;
        mosi_d    = mosi_q;
        armed_d   = armed_q | !ctrl_io.spi_start_i;
        if (!ctrl_io.spi_soft_rst_i) begin
            state_d   = StIdle;
            bit_cnt_d = '0;
            mosi_d    = 1'b1;
            armed_d   = 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (accept) begin
                        armed_d   = 1'b0;
                        div_d     = ctrl_io.clock_divider_i;
                        // Bit order is folded into the shift register once here.
                        tx_sr_d   = ctrl_io.spi_fbo_i ? ctrl_io.instruction_sd_i : cmd_rev;
                        bit_cnt_d = '0;
                        if (need_pwrup) begin
                            state_d = StPwrup;
                        end else begin
                            state_d = StTx;
                            mosi_d  = tx_sr_d[CMD_W-1];
                        end
                    end
                end
`ifdef SD_SPI_POWERUP_CLKS_EN
                StPwrup: begin
                    if (sck_fall) begin
                        if (bit_cnt_q == CNT_W'(PWRUP_CLKS_DEF - 1)) begin
                            state_d   = StTx;
                            bit_cnt_d = '0;
                            mosi_d    = tx_sr_q[CMD_W-1];
                        end else begin
                            bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        end
                    end
                end
`endif
                StTx: begin
                    if (sck_fall) begin
                        if (bit_cnt_q == CNT_W'(CMD_W - 1)) begin
                            state_d   = StRx;
                            bit_cnt_d = '0;
                            mosi_d    = 1'b1;
                        end else begin
                            bit_cnt_d = bit_cnt_q + CNT_W'(1);
                            tx_sr_d   = tx_sr_q << 1;
                            mosi_d    = tx_sr_d[CMD_W-1];
                        end
                    end
                end
                StRx: begin
                    if (sck_rise) begin
                        rx_sr_d = {rx_sr_q[RSP_W-2:0], sd_miso_i};
                    end
                    if (sck_fall) begin
                        if (bit_cnt_q == CNT_W'(RSP_W - 1)) begin
                            state_d   = StDone;
                            bit_cnt_d = '0;
                            data_d    = rx_sr_q;
                        end else begin
                            bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        end
                    end
                end
                StDone:  state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge spi_clk_i or negedge spi_rst_i) begin
        if (!spi_rst_i) begin
            state_q   <= StIdle;
            bit_cnt_q <= '0;
            tx_sr_q   <= '0;
            rx_sr_q   <= '0;
            data_q    <= '0;
            div_q     <= DivH1;
            mosi_q    <= 1'b1;
            armed_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            tx_sr_q   <= tx_sr_d;
            rx_sr_q   <= rx_sr_d;
            data_q    <= data_d;
            div_q     <= div_d;
            mosi_q    <= mosi_d;
            armed_q   <= armed_d;
        end
    end

    sd_spi_clkgen u_clkgen (
        .clk_i   (spi_clk_i),
        .rst_ni  (spi_rst_i),
        .en_i    (busy),
        .abort_i (!ctrl_io.spi_soft_rst_i),
        .div_i   (div_q),
        .sck_o   (sd_sck_o),
        .rise_o  (sck_rise),
        .fall_o  (sck_fall)
    );

    assign ctrl_io.spi_data_o = data_q;
    assign ctrl_io.spi_done_o = (state_q == StDone);
    assign ctrl_io.spi_busy_o = busy;
    assign sd_cs_n_o          = !(state_q inside {StTx, StRx});
    assign sd_mosi_o          = mosi_q;

endmodule

// File: tb/tb_sd_spi_master.sv
// Self-checking bench for sd_spi_master: directed and randomized transactions
// checked against a frame-level card/controller model.
module tb_sd_spi_master;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic sck, cs_n, mosi, miso;

    always #5 clk = ~clk;

    sd_spi_if bus ();

    sd_spi_master dut (
        .spi_clk_i (clk),
        .spi_rst_i (rst_n),
        .ctrl_io   (bus),
        .sd_sck_o  (sck),
        .sd_cs_n_o (cs_n),
        .sd_mosi_o (mosi),
        .sd_miso_i (miso)
    );

    int          errors = 0;
    int          checks = 0;
    bit          pwrup_pending;
    logic [79:0] last_data;
    logic [47:0] last_tx;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One transaction from the controller side, with a mode-0 card on MISO that
    // presents rsp MSB-first across the 80 response-window SCK periods.
    task automatic do_txn(input string tag, input logic [47:0] cmd, input bit fbo,
                          input logic [1:0] div, input logic [79:0] rsp, input bit hold);
        int h, pre_exp, t_cs, t_rise1, t_fall1, t_done, pre_rises, rises, rx_ones, idx;
        logic [47:0] tx_exp, tx_got;
        logic [79:0] data_got;
        logic        prev_sck, done_cs;
        h = 1 << div;
        pre_exp = pwrup_pending ? 80 : 0;
        for (int i = 0; i < 48; i++) tx_exp[47-i] = fbo ? cmd[47-i] : cmd[i];
        t_cs = -1; t_rise1 = -1; t_fall1 = -1; t_done = -1;
        pre_rises = 0; rises = 0; rx_ones = 0;
        tx_got = '0; data_got = '0; prev_sck = 1'b0; done_cs = 1'b0;
        miso = 1'b1;
        @(posedge clk); #1;
        bus.spi_start_i      = 1'b1;
        bus.spi_fbo_i        = fbo;
        bus.clock_divider_i  = div;
        bus.instruction_sd_i = cmd;
        for (int t = 0; t < 6000; t++) begin
            @(negedge clk);
            if (t == 1) begin
                check({tag, ".busy_t1"}, bus.spi_busy_o, 1);
                check({tag, ".cs_t1"}, cs_n, (pre_exp != 0) ? 1 : 0);
                check({tag, ".data_held"}, bus.spi_data_o, last_data);
                if (!hold) bus.spi_start_i = 1'b0;
                // Inputs change mid-flight; the transaction must use latched values.
                bus.instruction_sd_i = ~cmd;
                bus.spi_fbo_i        = ~fbo;
                bus.clock_divider_i  = ~div;
            end
            if (!cs_n && t_cs < 0) t_cs = t;
            if (sck && !prev_sck) begin
                if (cs_n) begin
                    pre_rises++;
                end else begin
                    if (rises == 0) t_rise1 = t;
                    if (rises < 48) tx_got[47-rises] = mosi;
                    else if (mosi) rx_ones++;
                    rises++;
                end
            end
            if (!sck && prev_sck && t_rise1 >= 0 && t_fall1 < 0) t_fall1 = t;
            prev_sck = sck;
            idx = 127 - rises;
            miso = (rises >= 48 && rises < 128) ? rsp[idx] : 1'b1;
            if (bus.spi_done_o) begin
                t_done   = t;
                data_got = bus.spi_data_o;
                done_cs  = cs_n;
                break;
            end
        end
        check({tag, ".pwrup_clks"}, pre_rises, pre_exp);
        check({tag, ".cs_fall_t"}, t_cs, 1 + pre_exp * 2 * h);
        check({tag, ".first_rise"}, t_rise1 - t_cs, h);
        check({tag, ".sck_high"}, t_fall1 - t_rise1, h);
        check({tag, ".tx_stream"}, tx_got, tx_exp);
        check({tag, ".rx_mosi_ones"}, rx_ones, 80);
        check({tag, ".done_t"}, t_done - t_cs, 256 * h);
        check({tag, ".cs_at_done"}, done_cs, 1);
        check({tag, ".data"}, data_got, rsp);
        @(negedge clk);
        check({tag, ".done_pulse"}, bus.spi_done_o, 0);
        check({tag, ".busy_after"}, bus.spi_busy_o, 0);
        last_tx       = tx_got;
        last_data     = rsp;
        pwrup_pending = 1'b0;
    endtask

    initial begin
        logic [47:0] c;
        logic [79:0] r;
        logic [79:0] saved;
        int          bad, done_seen, data_moved;

        bus.spi_soft_rst_i   = 1'b1;
        bus.spi_start_i      = 1'b0;
        bus.spi_fbo_i        = 1'b1;
        bus.clock_divider_i  = 2'b00;
        bus.instruction_sd_i = '0;
        miso                 = 1'b1;
        last_data            = '0;
        last_tx              = '0;
`ifdef SD_SPI_POWERUP_CLKS_EN
        pwrup_pending = 1'b1;
`else
        pwrup_pending = 1'b0;
`endif

        repeat (3) @(negedge clk);
        check("rst.sck", sck, 0);
        check("rst.cs_n", cs_n, 1);
        check("rst.mosi", mosi, 1);
        check("rst.done", bus.spi_done_o, 0);
        check("rst.busy", bus.spi_busy_o, 0);
        check("rst.data", bus.spi_data_o, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle.cs_n", cs_n, 1);
        check("idle.sck", sck, 0);

        // Divider 00, MSB first, CMD0-style frame with an R1 of 0x01 after 0xFF.
        do_txn("cmd0", 48'h4000_0000_0095, 1'b1, 2'b00, {16'hFF01, 64'hFFFF_FFFF_FFFF_FFFF}, 1'b0);
        check("cmd0.rsp_b9", bus.spi_data_o[79:72], 8'hFF);
        check("cmd0.rsp_b8", bus.spi_data_o[71:64], 8'h01);

        // LSB first: first bit on the wire is bit 0 of 0x87, last is bit 47.
        r[79:64] = 16'($urandom); r[63:32] = $urandom; r[31:0] = $urandom;
        do_txn("cmd8", 48'h4800_0001_AA87, 1'b0, 2'b01, r, 1'b0);
        check("cmd8.first_bit", last_tx[47], 1);
        check("cmd8.last_bit", last_tx[0], 0);

        // Slowest divider.
        c[47:32] = 16'($urandom); c[31:0] = $urandom;
        r[79:64] = 16'($urandom); r[63:32] = $urandom; r[31:0] = $urandom;
        do_txn("div3", c, 1'b1, 2'b11, r, 1'b0);

        for (int k = 0; k < 6; k++) begin
            c[47:32] = 16'($urandom); c[31:0] = $urandom;
            r[79:64] = 16'($urandom); r[63:32] = $urandom; r[31:0] = $urandom;
            do_txn($sformatf("rnd%0d", k), c, 1'($urandom), 2'($urandom_range(0, 2)), r, 1'b0);
        end

        // Start held high across done must not retrigger.
        c[47:32] = 16'($urandom); c[31:0] = $urandom;
        r[79:64] = 16'($urandom); r[63:32] = $urandom; r[31:0] = $urandom;
        do_txn("hold", c, 1'b0, 2'b00, r, 1'b1);
        bad = 0;
        repeat (40) begin
            @(negedge clk);
            if (!cs_n || bus.spi_busy_o) bad++;
        end
        check("hold.no_retrigger", bad, 0);
        @(posedge clk); #1 bus.spi_start_i = 1'b0;
        c[47:32] = 16'($urandom); c[31:0] = $urandom;
        r[79:64] = 16'($urandom); r[63:32] = $urandom; r[31:0] = $urandom;
        do_txn("rearm", c, 1'b1, 2'b00, r, 1'b0);

        // Soft reset in the middle of the command phase.
        saved = last_data;
        c[47:32] = 16'($urandom); c[31:0] = $urandom;
        @(posedge clk); #1;
        bus.spi_start_i      = 1'b1;
        bus.spi_fbo_i        = 1'b1;
        bus.clock_divider_i  = 2'b00;
        bus.instruction_sd_i = c;
        @(posedge clk); #1 bus.spi_start_i = 1'b0;
        repeat (30) @(posedge clk);
        @(negedge clk);
        check("soft.busy_before", bus.spi_busy_o, 1);
        @(posedge clk); #1 bus.spi_soft_rst_i = 1'b0;
        @(posedge clk); #1 bus.spi_soft_rst_i = 1'b1;
        @(negedge clk);
        check("soft.cs_n", cs_n, 1);
        check("soft.sck", sck, 0);
        check("soft.mosi", mosi, 1);
        check("soft.busy", bus.spi_busy_o, 0);
        done_seen = 0; data_moved = 0;
        repeat (600) begin
            @(negedge clk);
            if (bus.spi_done_o) done_seen++;
            if (bus.spi_data_o !== saved) data_moved++;
        end
        check("soft.no_done", done_seen, 0);
        check("soft.data_kept", data_moved, 0);

        c[47:32] = 16'($urandom); c[31:0] = $urandom;
        r[79:64] = 16'($urandom); r[63:32] = $urandom; r[31:0] = $urandom;
        do_txn("post_soft", c, 1'b0, 2'b10, r, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sd_spi_master.md
# sd_spi_master

SPI master PHY that sits directly downstream of the SD-card command controller. It takes a 48-bit SD command frame plus framing controls and shifts the frame out on MOSI. It then clocks in an 80-bit response window from MISO and returns the captured window with a one-cycle done pulse. It owns SCK, CS_n and the card-side pins.

## Interface
- CMD_W, 48, command frame width in bits
- RSP_W, 80, response window width in bits
- PWRUP_CLKS, 80, dummy SCK cycles with CS_n high before the first transaction after reset (only with the macro defined)

- spi_clk_i  input  1  system clock
- spi_rst_i  input  1  asynchronous, active-low reset
- spi_soft_rst_i  input  1  synchronous, active-low abort from the controller
- spi_start_i  input  1  active-high request level
- spi_fbo_i  input  1  1 = transmit MSB first, 0 = LSB first
- clock_divider_i  input  2  SCK half-period select
- instruction_sd_i  input  48  command frame
- spi_data_o  output  80  captured response window, MSB = first bit received
- spi_done_o  output  1  one-cycle completion pulse
- spi_busy_o  output  1  transaction in progress
- sd_sck_o  output  1  SPI clock, mode 0
- sd_cs_n_o  output  1  chip select, active-low
- sd_mosi_o  output  1  serial data to card
- sd_miso_i  input  1  serial data from card

## Operation
- Reset values: sd_sck_o=0, sd_cs_n_o=1, sd_mosi_o=1, spi_done_o=0, spi_busy_o=0, spi_data_o=0.
- States:
  - IDLE: start accepted when spi_start_i=1 and armed=1.
    - On accept, latch instruction_sd_i, spi_fbo_i and clock_divider_i; go to TX.
  - TX: CMD_W bits, in the order selected by latched fbo. Then go to RX.
  - RX: RSP_W SCK cycles with MOSI held at 1. MISO is shifted in MSB-first regardless of fbo.
  - DONE: one cycle. spi_done_o=1, spi_data_o updated, CS_n released. Then go to IDLE.
- Armed flag:
  - Cleared on accept.
  - Set again only after spi_start_i is observed low for at least one cycle.
  - A held-high start_i therefore never issues back-to-back transactions.
- spi_start_i while busy: ignored. Inputs are not re-sampled mid-transaction.
- spi_soft_rst_i=0 in any state:
  - Next cycle the block is in IDLE with CS_n=1, SCK=0, MOSI=1 and busy=0.
  - No done pulse is issued; spi_data_o keeps its previous value.
  - Armed is cleared.
- spi_data_o holds its value until the next DONE.

## Timing
- Half-period H = 2^clock_divider clk cycles (00→1, 01→2, 10→4, 11→8), so SCK = clk/(2H).
- Accept cycle N:
  - At N+1, CS_n=0, busy=1, and MOSI carries the first TX bit.
  - First SCK rising edge occurs at N+1+H.
- MOSI changes only on SCK falling edges. MISO is sampled on SCK rising edges.
- SCK idles low, and MOSI idles high.
- Transaction length: (CMD_W+RSP_W)·2H clk cycles from CS_n fall to the last falling edge, i.e. 256 cycles at divider 00.
- spi_done_o asserts the cycle after the last falling edge. CS_n rises in the same cycle.
- Minimum gap between transactions is 2 cycles (DONE plus start low).

## Configuration
- SD_SPI_POWERUP_CLKS_EN defined:
  - A PWRUP state is entered first after reset.
  - It issues PWRUP_CLKS SCK cycles with CS_n=1 and MOSI=1 at the divider sampled on the first accept.
  - It then proceeds into TX without releasing busy.
  - It runs once per hard reset, not on soft reset.
- Macro undefined: the PWRUP state and its counter are absent, and the first accept goes straight to TX.

## Structure
- Package sd_spi_pkg:
  - state enum (IDLE, PWRUP, TX, RX, DONE)
  - CMD_W/RSP_W defaults
  - divider encoding constants
  - bit-counter width (8)
- Sub-module sd_spi_clkgen:
  - Half-period counter producing SCK plus one-cycle rise/fall strobes.
  - Enabled only while busy.
  - Reset to SCK=0 on abort.

## Test plan
- Divider 00, fbo=1, command 0x400000000095, MISO driven as 0xFF01 followed by 0xFF…:
  - MOSI bit stream 0x40…95 MSB-first.
  - done at 256 cycles after CS_n falls.
  - spi_data_o[79:72]=0xFF, [71:64]=0x01.
- fbo=0, command 0x48000001AA87: MOSI first bit = 1 (bit0 of 0x87) and last TX bit = 0 (bit47).
- Divider 11: SCK high/low for 8 cycles each; done at 2048 cycles.
- start_i held high across done: exactly one transaction; a second starts only after start_i toggles low.
- Soft reset pulse mid-TX: CS_n=1 next cycle, no done pulse, spi_data_o unchanged, next start works normally.
- With SD_SPI_POWERUP_CLKS_EN: the first transaction shows 80 SCK cycles with CS_n=1 before CS_n falls; the second transaction has none.
